// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared constants and the receiver state type for uart_rx.
// Build option: UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_FIFO_DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
`endif
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: core-facing UART receive port.
//   uart_in    head byte (8'h00 when empty)
//   uart_empty FIFO holds no bytes
//   uart_rdreq pop head this cycle
//   frame_err  one-cycle framing/parity error pulse
//   overrun    one-cycle dropped-byte pulse
// master = receiver side, slave = core side.
interface uart_rx_if;
  logic [uart_pkg::UART_DATA_W-1:0] uart_in;
  logic uart_empty;
  logic uart_rdreq;
  logic frame_err;
  logic overrun;
  modport master(output uart_in, uart_empty, frame_err, overrun, input uart_rdreq);
  modport slave(input uart_in, uart_empty, frame_err, overrun, output uart_rdreq);
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: show-ahead FIFO; a push into a full FIFO lands only if a pop
// happens in the same cycle.
//   i_push/i_data  write request and byte
//   i_pop          pop head (ignored when empty)
//   o_head         head entry, zero when empty
//   o_empty/o_full occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign w_pop = i_pop & ~o_empty;
  // When full, the slot being popped is the one the write pointer targets.
  assign w_push = i_push & (~o_full | w_pop);
  assign o_head = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a show-ahead byte FIFO.
//   clk, rst_n  clock, asynchronous active-low reset
//   rxd         asynchronous serial line, idle high
//   bus         uart_rx_if.master (uart_in, uart_empty, uart_rdreq, frame_err, overrun)
// Build option: UART_RX_PARITY_EN selects 8E1 with a parity check.
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic clk,
  input logic rst_n,
  input logic rxd,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [1:0] r_sync;
  logic w_rxd_s;
  rx_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic [UART_DATA_W-1:0] r_data, w_data_nx;
  logic w_push, w_ferr, w_full;
  logic r_frame_err, r_overrun;
`ifdef UART_RX_PARITY_EN
  logic r_par_err, w_par_err_nx;
`endif
  assign w_rxd_s = r_sync[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_frame_err <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_idx <= w_idx_nx;
      r_data <= w_data_nx;
      r_frame_err <= w_ferr;
      r_overrun <= w_push & w_full & ~bus.uart_rdreq;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_err_nx;
`endif
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt + 1'b1;
    w_idx_nx = r_idx;
    w_data_nx = r_data;
    w_push = 1'b0;
    w_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_nx = r_par_err;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (!w_rxd_s) w_state_nx = START;
      end
      START: if (r_cnt == HALF) begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        w_state_nx = w_rxd_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == LAST) begin
        w_cnt_nx = '0;
        w_data_nx[r_idx] = w_rxd_s;
        w_idx_nx = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (r_idx == 3'd7) w_state_nx = PARITY;
`else
        if (r_idx == 3'd7) w_state_nx = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (r_cnt == LAST) begin
        w_cnt_nx = '0;
        w_par_err_nx = ^r_data ^ w_rxd_s;
        w_state_nx = STOP;
      end
`endif
      // Leaves mid-stop-bit so a start bit at the nominal stop end is caught.
      STOP: if (r_cnt == LAST) begin
        w_cnt_nx = '0;
`ifdef UART_RX_PARITY_EN
        w_push = w_rxd_s & ~r_par_err;
        w_ferr = ~w_rxd_s | r_par_err;
`else
        w_push = w_rxd_s;
        w_ferr = ~w_rxd_s;
`endif
        w_state_nx = w_rxd_s ? IDLE : WAIT_HIGH;
      end
      // A held-low break must not look like a new start bit.
      WAIT_HIGH: begin
        w_cnt_nx = '0;
        if (w_rxd_s) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (r_data),
    .i_pop  (bus.uart_rdreq),
    .o_head (bus.uart_in),
    .o_empty(bus.uart_empty),
    .o_full (w_full)
  );
  assign bus.frame_err = r_frame_err;
  assign bus.overrun = r_overrun;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end feeding the core's memory-mapped UART port. Synchronises the asynchronous `rxd` line, decodes 8N1 frames by mid-bit sampling, and buffers received bytes in a show-ahead FIFO. The output side presents the core-facing interface: `uart_in`, `uart_empty` and `uart_rdreq`.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per bit (50 MHz / 115200); minimum 8.
- `FIFO_DEPTH`, default 16: byte entries; power of two, minimum 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rxd`  in  1  serial line; idle high; asynchronous to clk.
- `uart_in`  out  8  FIFO head byte; 8'h00 whenever `uart_empty`=1.
- `uart_empty`  out  1  FIFO holds no bytes.
- `uart_rdreq`  in  1  pop head this cycle; ignored when `uart_empty`=1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low (or parity mismatch, see Configuration).
- `overrun`  out  1  one-cycle pulse: valid byte dropped because FIFO full.

## Operation
- Input synchroniser: 2 flops, reset to 1; FSM uses synchronised `rxd_s` only.
- Bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: `rxd_s`=0 -> START, cnt=0.
  - START: at cnt=CLKS_PER_BIT/2-1, if `rxd_s`=0 -> DATA with cnt=0 and bit index=0; if `rxd_s`=1 -> IDLE (glitch rejected, no pulse).
  - DATA: at cnt=CLKS_PER_BIT-1, shift `rxd_s` into bit[index] (LSB first). After bit 7 -> STOP (or PARITY).
  - STOP: at cnt=CLKS_PER_BIT-1, sample `rxd_s`.
    - Sample 1: push byte and go to IDLE.
    - Sample 0: pulse `frame_err`, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`=1, then IDLE (break condition never retriggers START).
- FIFO: wr_ptr/rd_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally; `count` has one extra bit.
- Push when full:
  - If `uart_rdreq`=1 the same cycle, push and pop both take effect; count unchanged.
  - Otherwise drop the byte and pulse `overrun`; FIFO contents untouched.
- Pop when empty: no effect; pointers and count unchanged.
- Simultaneous push and pop when not empty: both take effect; count unchanged.
- Reset mid-frame: FSM returns to IDLE, FIFO empties, partial byte is lost.

## Timing
- Reset values: `uart_empty`=1, `uart_in`=8'h00, `frame_err`=0, `overrun`=0; FSM=IDLE; pointers and count=0.
- Start edge on `rxd` to START entry: 3 clk (2 synchroniser flops + IDLE register).
- Stop-bit sample cycle N: at N+1, `uart_empty`=0 and `uart_in`=byte (push registered).
- `uart_rdreq` at cycle N: at N+1, head advances or `uart_empty` rises. Single-cycle pop, no wait states.
- `frame_err` and `overrun` are asserted exactly in cycle N+1 after the deciding sample.
- Back-to-back frames: STOP exits mid-stop-bit, so a start bit arriving at the nominal stop-bit end is caught.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1; the PARITY state follows DATA and samples at cnt=CLKS_PER_BIT-1.
  - If XOR of data bits and the parity bit is 1: byte discarded at STOP, `frame_err` pulses at STOP time, and the FSM returns to IDLE (WAIT_HIGH only if stop is also low).
- Not defined: PARITY state and its logic are absent; frame is 8N1.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum.
  - `UART_DATA_W`=8.
  - Default `CLKS_PER_BIT` and `FIFO_DEPTH` constants.
- Sub-module `sync_fifo`:
  - Parameters: width, depth.
  - Ports: push/data, pop/head, empty, full; implements the push-when-full-with-pop rule.
  - `uart_rx` holds the synchroniser, FSM, and the `overrun`/`frame_err` pulses.

## Test plan
- All tests use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Send 8'hA5, 8N1 -> `uart_empty` falls 1 clk after the stop sample; `uart_in`=8'hA5; `uart_rdreq` for 1 clk -> `uart_empty`=1, `uart_in`=8'h00.
- `rxd` low pulse of 5 clk in IDLE -> no byte, no pulse, FSM back in IDLE.
- Frame 8'h3C with stop bit low, then line held low 40 clk -> one `frame_err` pulse, FIFO empty, no new frame until `rxd` returns high.
- Send 8'h01..8'h05 without popping -> FIFO holds 01..04, one `overrun` pulse on 05. Repeat with `uart_rdreq` asserted in the push cycle of 05 -> no overrun, FIFO holds 02..05.
- Assert `rst_n`=0 during DATA bit 4 of 8'hFF -> all outputs at reset values; the next clean frame 8'h81 is received correctly.
- With `UART_RX_PARITY_EN`: 8'h07 with parity 1 -> accepted; 8'h07 with parity 0 -> `frame_err`, FIFO empty.
